// File: rtl/crc8_serial_ctrl.sv
// Byte sequencer for a bit-serial CRC-8 (poly 0x2F): accepts framed bytes, feeds one bit per
// clock through crc_stage0, and presents the frame CRC on a valid/ready output.

module crc_stage0 (
  input  logic [7:0] in_crc_reg,
  input  logic       din,
  output logic [7:0] out_crc_next
);
  logic fb;

  always_comb begin
    fb           = in_crc_reg[7] ^ din;
    out_crc_next = {in_crc_reg[6:0], 1'b0} ^ (fb ? 8'h2F : 8'h00);
  end
endmodule

module crc8_serial_ctrl #(
  parameter logic [7:0] INIT      = 8'h00,
  parameter bit         MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_sof,
  input  logic       s_eof,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_crc,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] crc_q, crc_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] cnt_q, cnt_d;
  logic       eof_l_q, eof_l_d;
  logic       in_frame_q, in_frame_d;
  logic       din;
  logic [7:0] crc_next;

  assign din = MSB_FIRST ? sh_q[7] : sh_q[0];

  crc_stage0 u_stage (
    .in_crc_reg  (crc_q),
    .din         (din),
    .out_crc_next(crc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      crc_q      <= INIT;
      sh_q       <= 8'h00;
      cnt_q      <= 3'd0;
      eof_l_q    <= 1'b0;
      in_frame_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      eof_l_q    <= eof_l_d;
      in_frame_q <= in_frame_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    eof_l_d    = eof_l_q;
    in_frame_d = in_frame_q;
    if (clr) begin
      state_d    = IDLE;
      crc_d      = INIT;
      in_frame_d = 1'b0;
      eof_l_d    = 1'b0;
      cnt_d      = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_valid) begin
            sh_d    = s_data;
            eof_l_d = s_eof;
            cnt_d   = 3'd0;
            state_d = SHIFT;
            // SOF, or any byte arriving outside a frame, starts a fresh CRC
            if (s_sof || !in_frame_q) begin
              crc_d      = INIT;
              in_frame_d = 1'b1;
            end
          end
        end
        SHIFT: begin
          crc_d = crc_next;
          sh_d  = MSB_FIRST ? {sh_q[6:0], 1'b0} : {1'b0, sh_q[7:1]};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = eof_l_q ? DONE : IDLE;
        end
        DONE: begin
          if (m_ready) begin
            state_d    = IDLE;
            in_frame_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign s_ready = (state_q == IDLE) && !clr && rst;
  assign m_valid = (state_q == DONE);
  assign m_crc   = crc_q;
  assign busy    = in_frame_q;
endmodule

// File: tb/tb_crc8_serial_ctrl.sv
// Self-checking bench for crc8_serial_ctrl: two instances (seed 0x00 and 0xFF) share stimulus,
// results are compared with a byte-wise CRC-8 reference model.
`timescale 1ns/1ps
module tb_crc8_serial_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_sof = 1'b0;
  logic       s_eof = 1'b0;
  logic       m_ready = 1'b0;
  logic       s_ready0, m_valid0, busy0;
  logic [7:0] m_crc0;
  logic       s_ready1, m_valid1, busy1;
  logic [7:0] m_crc1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  crc8_serial_ctrl #(.INIT(8'h00), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid), .s_ready(s_ready0),
    .s_data(s_data), .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid0),
    .m_ready(m_ready), .m_crc(m_crc0), .busy(busy0)
  );

  crc8_serial_ctrl #(.INIT(8'hFF), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid), .s_ready(s_ready1),
    .s_data(s_data), .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid1),
    .m_ready(m_ready), .m_crc(m_crc1), .busy(busy1)
  );

  // Reference: classic MSB-first byte-wise CRC-8 update
  function automatic logic [7:0] crc_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h2F) : (c << 1);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents a byte and returns one cycle after the accepting edge (cycle T+1)
  task automatic send_byte(input logic [7:0] d, input logic sof, input logic eof);
    int n;
    s_valid = 1'b1; s_data = d; s_sof = sof; s_eof = eof;
    #1;
    n = 0;
    while (!s_ready0 && n < 50) begin tick(); n++; end
    if (!s_ready0) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: s_ready=%0b required 1 within 50 cycles", s_ready0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
  endtask

  // Waits for m_valid (bounded), captures both CRCs, holds off m_ready, then completes handshake
  task automatic get_crc(input int hold, output logic [7:0] c0, output logic [7:0] c1, output bit ok);
    int n;
    n = 0;
    while (!m_valid0 && n < 50) begin tick(); n++; end
    ok = m_valid0;
    c0 = m_crc0; c1 = m_crc1;
    for (int i = 0; i < hold; i++) tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; clr = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_tests++;
    if (s_ready0 !== 1'b0 || m_valid0 !== 1'b0 || m_crc0 !== 8'h00 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_during: rdy=%0b vld=%0b crc=%h busy=%0b required 0 0 00 0",
               s_ready0, m_valid0, m_crc0, busy0);
    end
    do_reset();
    n_tests++;
    if (s_ready0 !== 1'b1 || m_valid0 !== 1'b0 || m_crc0 !== 8'h00 || busy0 !== 1'b0 || m_crc1 !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_after: rdy=%0b vld=%0b crc=%h busy=%0b crc1=%h required 1 0 00 0 FF",
               s_ready0, m_valid0, m_crc0, busy0, m_crc1);
    end
  endtask

  task automatic test_single_byte();
    bit bad;
    send_byte(8'h01, 1'b1, 1'b1);
    bad = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (m_valid0 !== 1'b0 || s_ready0 !== 1'b0 || busy0 !== 1'b1) bad = 1'b1;
      tick();
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL single_shift_window: m_valid/s_ready/busy wrong in T+1..T+8, required 0/0/1");
    end
    n_tests++;
    if (m_valid0 !== 1'b1 || m_crc0 !== 8'h2F || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_result: vld=%0b crc=%h busy=%0b required 1 2F 1", m_valid0, m_crc0, busy0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_tests++;
    if (m_valid0 !== 1'b0 || s_ready0 !== 1'b1 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_handshake: vld=%0b rdy=%0b busy=%0b required 0 1 0", m_valid0, s_ready0, busy0);
    end
  endtask

  task automatic test_two_byte();
    logic [7:0] c0, c1;
    bit ok, bad;
    send_byte(8'h80, 1'b1, 1'b1);
    get_crc(0, c0, c1, ok);
    n_tests++;
    if (!ok || c0 !== 8'hE3) begin
      n_fail++;
      $display("FAIL byte80: crc=%h ok=%0b required E3", c0, ok);
    end
    send_byte(8'h01, 1'b1, 1'b0);
    bad = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (s_ready0 !== 1'b0) bad = 1'b1;
      tick();
    end
    n_tests++;
    if (bad || s_ready0 !== 1'b1 || m_valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL two_byte_gap: s_ready=%0b m_valid=%0b at T+9, required 1 0 after 8 low cycles",
               s_ready0, m_valid0);
    end
    send_byte(8'h00, 1'b0, 1'b1);
    get_crc(0, c0, c1, ok);
    n_tests++;
    if (!ok || c0 !== 8'hE9) begin
      n_fail++;
      $display("FAIL two_byte: crc=%h ok=%0b required E9", c0, ok);
    end
  endtask

  task automatic test_init_ff();
    logic [7:0] c0, c1;
    bit ok;
    send_byte(8'h00, 1'b1, 1'b1);
    get_crc(0, c0, c1, ok);
    n_tests++;
    if (!ok || c1 !== 8'h42 || c0 !== 8'h00) begin
      n_fail++;
      $display("FAIL init_ff: crc1=%h crc0=%h required 42 00", c1, c0);
    end
    send_byte(8'h01, 1'b1, 1'b1);
    get_crc(0, c0, c1, ok);
    n_tests++;
    if (!ok || c0 !== 8'h2F || c1 !== crc_byte(8'hFF, 8'h01)) begin
      n_fail++;
      $display("FAIL back_to_back_seed: crc0=%h crc1=%h required 2F %h", c0, c1, crc_byte(8'hFF, 8'h01));
    end
  endtask

  task automatic test_backpressure();
    bit bad;
    logic [7:0] held;
    send_byte(8'hA7, 1'b1, 1'b1);
    repeat (8) tick();
    held = m_crc0;
    bad = (m_valid0 !== 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (m_valid0 !== 1'b1 || m_crc0 !== held || s_ready0 !== 1'b0) bad = 1'b1;
      tick();
    end
    n_tests++;
    if (bad || held !== crc_byte(8'h00, 8'hA7)) begin
      n_fail++;
      $display("FAIL backpressure_hold: crc=%h vld=%0b rdy=%0b required stable %h 1 0",
               m_crc0, m_valid0, s_ready0, crc_byte(8'h00, 8'hA7));
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_tests++;
    if (m_valid0 !== 1'b0 || s_ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: vld=%0b rdy=%0b required 0 1", m_valid0, s_ready0);
    end
  endtask

  task automatic test_clr();
    logic [7:0] c0, c1;
    bit ok, bad;
    send_byte(8'hAA, 1'b1, 1'b1);
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    n_tests++;
    if (s_ready0 !== 1'b1 || busy0 !== 1'b0 || m_valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_shift: rdy=%0b busy=%0b vld=%0b required 1 0 0", s_ready0, busy0, m_valid0);
    end
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (m_valid0 !== 1'b0) bad = 1'b1;
      tick();
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL clr_no_output: m_valid=1 seen after clr, required 0");
    end
    s_valid = 1'b1; s_data = 8'h33; s_sof = 1'b1; s_eof = 1'b1; clr = 1'b1;
    #1;
    n_tests++;
    if (s_ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_blocks_ready: s_ready=%0b required 0", s_ready0);
    end
    @(posedge clk); #1;
    clr = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
    #1;
    n_tests++;
    if (busy0 !== 1'b0 || s_ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_no_accept: busy=%0b rdy=%0b required 0 1", busy0, s_ready0);
    end
    send_byte(8'h01, 1'b1, 1'b1);
    get_crc(0, c0, c1, ok);
    n_tests++;
    if (!ok || c0 !== 8'h2F) begin
      n_fail++;
      $display("FAIL clr_recover: crc=%h ok=%0b required 2F", c0, ok);
    end
  endtask

  task automatic test_async_rst();
    send_byte(8'h5A, 1'b1, 1'b0);
    repeat (3) tick();
    #2; rst = 1'b0; #1;
    n_tests++;
    if (s_ready0 !== 1'b0 || m_valid0 !== 1'b0 || m_crc0 !== 8'h00 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_frame: rdy=%0b vld=%0b crc=%h busy=%0b required 0 0 00 0",
               s_ready0, m_valid0, m_crc0, busy0);
    end
    @(negedge clk); rst = 1'b1;
    tick();
    send_byte(8'h37, 1'b1, 1'b1);
    repeat (9) tick();
    #2; rst = 1'b0; #1;
    n_tests++;
    if (m_valid0 !== 1'b0 || m_crc0 !== 8'h00 || busy0 !== 1'b0 || m_crc1 !== 8'hFF) begin
      n_fail++;
      $display("FAIL rst_in_done: vld=%0b crc=%h busy=%0b crc1=%h required 0 00 0 FF",
               m_valid0, m_crc0, busy0, m_crc1);
    end
    @(negedge clk); rst = 1'b1;
    tick();
    n_tests++;
    if (s_ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_release: s_ready=%0b required 1", s_ready0);
    end
  endtask

  task automatic test_sof_reseed();
    logic [7:0] c0, c1;
    bit ok;
    send_byte(8'h55, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b1);
    get_crc(0, c0, c1, ok);
    n_tests++;
    if (!ok || c0 !== 8'h2F || c1 !== crc_byte(8'hFF, 8'h01)) begin
      n_fail++;
      $display("FAIL sof_reseed: crc0=%h crc1=%h required 2F %h", c0, c1, crc_byte(8'hFF, 8'h01));
    end
  endtask

  task automatic test_random();
    logic [7:0] c0, c1, e0, e1, b;
    bit ok;
    int len;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 4);
      e0 = 8'h00; e1 = 8'hFF;
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        e0 = crc_byte(e0, b);
        e1 = crc_byte(e1, b);
        send_byte(b, (i == 0) ? 1'($urandom_range(0, 1)) : 1'b0, (i == len - 1));
        repeat ($urandom_range(0, 2)) tick();
      end
      get_crc($urandom_range(0, 3), c0, c1, ok);
      n_tests++;
      if (!ok || c0 !== e0 || c1 !== e1) begin
        n_fail++;
        $display("FAIL random_frame%0d: crc0=%h crc1=%h ok=%0b required %h %h", f, c0, c1, ok, e0, e1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_two_byte();
    test_init_ff();
    test_backpressure();
    test_clr();
    test_async_rst();
    test_sof_reseed();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/crc8_serial_ctrl.md
# crc8_serial_ctrl

Byte-level sequencer for the bit-serial CRC-8 stage (polynomial x^8+x^5+x^3+x^2+x+1, 0x2F, no reflection, no final XOR). It accepts bytes on a valid/ready stream with start/end-of-frame markers. Each byte is shifted through one `crc_stage0` instance, one bit per clock, and the CRC register is owned here. At end of frame it presents the 8-bit result on a valid/ready output. It sits between the framing logic and any consumer of frame checksums.

## Interface
- `INIT`, 8'h00: CRC seed loaded at the start of every frame.
- `MSB_FIRST`, 1: 1 = feed data bit 7 first; 0 = feed bit 0 first.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous active-high abort; priority over all other inputs.
- `s_valid`  in  1  input byte valid.
- `s_ready`  out  1  controller can accept a byte.
- `s_data`  in  8  input byte.
- `s_sof`  in  1  byte is first of frame (qualified by `s_valid`).
- `s_eof`  in  1  byte is last of frame (qualified by `s_valid`).
- `m_valid`  out  1  frame CRC available.
- `m_ready`  in  1  consumer takes the CRC.
- `m_crc`  out  8  CRC of the completed frame.
- `busy`  out  1  high while in a frame (after SOF accepted, until the result is taken).

## Operation
- Internal state:
  - `crc_reg[7:0]`, feeds the stage's `in_crc_reg`.
  - `sh[7:0]`, the byte shift register.
  - `cnt[2:0]`, the bit counter.
  - `eof_l`, the latched EOF flag.
  - `in_frame`, the frame-open flag.
  - FSM {IDLE, SHIFT, DONE}.
- IDLE:
  - `s_ready`=1.
  - On `s_valid`: latch `s_data` into `sh`, latch `s_eof` into `eof_l`, set `cnt`=0, go to SHIFT.
  - If `s_sof` or !`in_frame`, `crc_reg`<=`INIT` and `in_frame`<=1. Otherwise `crc_reg` holds and the running CRC continues.
- SHIFT:
  - `s_ready`=0.
  - `din` = `sh[7]` (MSB_FIRST=1) or `sh[0]`.
  - Each cycle: `crc_reg`<=`out_crc_next`, shift `sh` one position toward the fed bit, `cnt`++.
  - At `cnt`==7: go to DONE if `eof_l`, else go to IDLE.
- DONE:
  - `m_valid`=1, `m_crc`=`crc_reg`, `s_ready`=0.
  - On `m_ready`: go to IDLE, `in_frame`<=0.
  - `m_crc` is stable while `m_valid`=1 and `m_ready`=0.
- `s_sof` and `s_eof` on the same byte: single-byte frame.
- SOF on a byte while `in_frame`=1: the open frame is discarded and the CRC is reseeded (no error indication).
- Byte without SOF while `in_frame`=0: treated as an implicit SOF and seeded with `INIT`.
- `clr`=1: FSM<=IDLE, `crc_reg`<=`INIT`, `in_frame`<=0, `eof_l`<=0, `cnt`<=0. `m_valid` drops the next cycle. A byte presented in the same cycle is not accepted (`s_ready` is forced to 0 while `clr`=1).
- `busy` = `in_frame`.
- `s_ready` is a function of state and `clr` only, never of `s_valid`.
- `m_valid` is a function of state only.

## Timing
- Reset (`rst`=0, async):
  - FSM=IDLE, `crc_reg`=`INIT`, `sh`=0, `cnt`=0, `eof_l`=0, `in_frame`=0.
  - Outputs: `s_ready`=1 after reset release (0 during reset), `m_valid`=0, `m_crc`=`INIT`, `busy`=0.
- Byte accepted at the edge ending cycle T:
  - Shifts occur in cycles T+1..T+8.
  - `crc_reg` is final at the edge ending T+8.
  - From cycle T+9: `s_ready`=1 (non-EOF byte) or `m_valid`=1 (EOF byte).
- Throughput: one byte per 9 cycles.
- Output handshake: `m_valid`∧`m_ready` in cycle D means the CRC is taken at the end of D and `s_ready`=1 in D+1.
- Reset or `clr` mid-SHIFT: the partial byte and frame are lost, with no output.

## Test plan
- `INIT`=0: single frame {0x01, SOF+EOF} -> `m_valid` exactly 9 cycles after acceptance, `m_crc`=0x2F; `busy` high from T+1 until the handshake.
- `INIT`=0: single byte 0x80 -> 0xE3. Two-byte frame 0x01 (SOF), 0x00 (EOF) -> 0xE9, with `s_ready` low for 8 cycles between bytes.
- `INIT`=0xFF: byte 0x00 SOF+EOF -> 0x42. Back-to-back frames seed independently: frame 2 = 0x01 -> 0x2F with `INIT`=0.
- Output backpressure: hold `m_ready`=0 for 5 cycles -> `m_valid` and `m_crc` stable, `s_ready`=0. Assert `m_ready` -> `m_valid` drops and `s_ready`=1 next cycle.
- `clr` in SHIFT cycle 4 of a frame -> IDLE next cycle, no `m_valid`. A subsequent 0x01 SOF+EOF frame -> 0x2F.
- Async `rst` asserted mid-frame and in DONE -> all outputs at reset values immediately. SOF mid-frame reseeds: 0x55 (SOF), then 0x01 (SOF+EOF) -> 0x2F.
